cmp_share_ctrl: RTL

- Controller that time-shares one external equality comparator (WIDTH-bit A/B in, equal out) between two requesters.
- Round-robin arbitration, valid/ready request handshake, registered comparator operands, and a held response with the requester ID.
- Keeps a saturating count of equal results delivered.
- Sits between requester logic and the comparator instance; the comparator itself stays outside this block.

---
 rtl/cmp_share_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/cmp_share_ctrl.sv
// Time-shares one external equality comparator between two requesters using
// round-robin grant, registered operands and a held response; counts equal results.
module cmp_share_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_equal,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_equal,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t state, next_state;
  logic   rr_ptr;
  logic   grant_id;
  logic   g_valid;
  logic   g_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    g_valid    = 1'b0;
    g_id       = 1'b0;
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state != IDLE);

    // Round-robin pointer only breaks ties; a lone requester is always served.
    if (req0_valid && req1_valid) begin
      g_valid = 1'b1;
      g_id    = rr_ptr;
    end else if (req0_valid) begin
      g_valid = 1'b1;
      g_id    = 1'b0;
    end else if (req1_valid) begin
      g_valid = 1'b1;
      g_id    = 1'b1;
    end

    case (state)
      IDLE: begin
        req0_ready = g_valid && !g_id;
        req1_ready = g_valid &&  g_id;
        if (g_valid) next_state = EVAL;
      end
      EVAL: next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      grant_id  <= 1'b0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_equal <= 1'b0;
      match_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (g_valid) begin
            cmp_a    <= g_id ? req1_a : req0_a;
            cmp_b    <= g_id ? req1_b : req0_b;
            grant_id <= g_id;
            rr_ptr   <= ~g_id;
          end
        end
        EVAL: begin
          rsp_equal <= cmp_equal;
          rsp_id    <= grant_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_equal && (match_cnt != '1))
              match_cnt <= match_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
